// File: rtl/sim_axi_ram_pkg.sv
// Shared types and constants for the behavioural AXI4 block-RAM slave.
// Burst encodings, response code, word offset and FSM state encodings.
package sim_axi_ram_pkg;

    typedef enum logic [1:0] {
        BurstFixed = 2'd0,
        BurstIncr  = 2'd1,
        BurstWrap  = 2'd2
    } burst_e;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    // Byte-offset bits of a 256-bit word.
    localparam int unsigned BYTE_OFS = 5;

    localparam logic StRdIdle  = 1'b0;
    localparam logic StRdBurst = 1'b1;

    localparam logic [1:0] StWrIdle = 2'd0;
    localparam logic [1:0] StWrData = 2'd1;
    localparam logic [1:0] StWrResp = 2'd2;

endpackage

// File: rtl/sim_axi_burst_addr.sv
// Next-beat address for one AXI channel: FIXED holds, INCR/WRAP step by 1 << size.
module sim_axi_burst_addr
    import sim_axi_ram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 48
) (
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [2:0]            size_i,
    input  logic [1:0]            burst_i,
    output logic [ADDR_WIDTH-1:0] next_addr_o
);

    always_comb begin
        case (burst_i)
            BurstFixed:           next_addr_o = addr_i;
            BurstIncr, BurstWrap: next_addr_o = addr_i + (ADDR_WIDTH'(1) << size_i);
            // Reserved encoding behaves like INCR.
            default:              next_addr_o = addr_i + (ADDR_WIDTH'(1) << size_i);
        endcase
    end

endmodule

// File: rtl/sim_axi_blk_ram.sv
// Behavioural AXI4 memory slave standing in for one HBM pseudo-channel.
// Independent read and write FSMs, one outstanding burst each, read-first memory.
module sim_axi_blk_ram
    import sim_axi_ram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 48,
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned MEM_DEPTH  = 4096
) (
    input  logic                    s_aclk,
    input  logic                    s_areset,
    input  logic [ID_WIDTH-1:0]     s_axi_arid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [1:0]              s_axi_arburst,
    input  logic [7:0]              s_axi_arlen,
    input  logic [2:0]              s_axi_arsize,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [ID_WIDTH-1:0]     s_axi_rid,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rlast,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [1:0]              s_axi_awburst,
    input  logic [7:0]              s_axi_awlen,
    input  logic [2:0]              s_axi_awsize,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wlast,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready
);

    localparam int unsigned StrbW = DATA_WIDTH / 8;
    localparam int unsigned IdxW  = $clog2(MEM_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    logic                  rd_state_q, rd_state_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d, rd_next;
    logic [7:0]            rd_len_q, rd_len_d, rd_cnt_q, rd_cnt_d;
    logic [2:0]            rd_size_q, rd_size_d;
    logic [1:0]            rd_burst_q, rd_burst_d;
    logic [ID_WIDTH-1:0]   rid_q, rid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rvalid_q, rvalid_d, rlast_q, rlast_d, arready_q, arready_d;

    logic [1:0]            wr_state_q, wr_state_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d, wr_next;
    logic [2:0]            wr_size_q, wr_size_d;
    logic [1:0]            wr_burst_q, wr_burst_d;
    logic                  awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;

    logic ar_hs, r_hs, aw_hs, w_hs;

    // Write bursts terminate on wlast alone.
    logic [7:0] unused_awlen;
    assign unused_awlen = s_axi_awlen;

    assign ar_hs = s_axi_arvalid & arready_q;
    assign r_hs  = rvalid_q & s_axi_rready;
    assign aw_hs = s_axi_awvalid & awready_q;
    assign w_hs  = s_axi_wvalid & wready_q;

    sim_axi_burst_addr #(.ADDR_WIDTH(ADDR_WIDTH)) u_rd_addr (
        .addr_i      (rd_addr_q),
        .size_i      (rd_size_q),
        .burst_i     (rd_burst_q),
        .next_addr_o (rd_next)
    );

    sim_axi_burst_addr #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr_addr (
        .addr_i      (wr_addr_q),
        .size_i      (wr_size_q),
        .burst_i     (wr_burst_q),
        .next_addr_o (wr_next)
    );

    always_comb begin
        rd_state_d = rd_state_q;
        rd_addr_d  = rd_addr_q;
        rd_len_d   = rd_len_q;
        rd_cnt_d   = rd_cnt_q;
        rd_size_d  = rd_size_q;
        rd_burst_d = rd_burst_q;
        rid_d      = rid_q;
        rdata_d    = rdata_q;
        rvalid_d   = rvalid_q;
        rlast_d    = rlast_q;
        arready_d  = arready_q;
        case (rd_state_q)
            StRdIdle: begin
                arready_d = 1'b1;
                if (ar_hs) begin
                    rd_addr_d  = s_axi_araddr;
                    rd_len_d   = s_axi_arlen;
                    rd_size_d  = s_axi_arsize;
                    rd_burst_d = s_axi_arburst;
                    rid_d      = s_axi_arid;
                    rd_cnt_d   = 8'd0;
                    rdata_d    = mem_q[s_axi_araddr[BYTE_OFS +: IdxW]];
                    rvalid_d   = 1'b1;
                    rlast_d    = (s_axi_arlen == 8'd0);
                    arready_d  = 1'b0;
                    rd_state_d = StRdBurst;
                end
            end
            default: begin
                if (r_hs && rlast_q) begin
                    rvalid_d   = 1'b0;
                    rlast_d    = 1'b0;
                    arready_d  = 1'b1;
                    rd_state_d = StRdIdle;
                end else if (r_hs) begin
                    rd_addr_d = rd_next;
                    rd_cnt_d  = rd_cnt_q + 8'd1;
                    rdata_d   = mem_q[rd_next[BYTE_OFS +: IdxW]];
                    rlast_d   = (rd_cnt_q + 8'd1 == rd_len_q);
                end
            end
        endcase
    end

    always_comb begin
        wr_state_d = wr_state_q;
        wr_addr_d  = wr_addr_q;
        wr_size_d  = wr_size_q;
        wr_burst_d = wr_burst_q;
        awready_d  = awready_q;
        wready_d   = wready_q;
        bvalid_d   = bvalid_q;
        case (wr_state_q)
            StWrIdle: begin
                awready_d = 1'b1;
                if (aw_hs) begin
                    wr_addr_d  = s_axi_awaddr;
                    wr_size_d  = s_axi_awsize;
                    wr_burst_d = s_axi_awburst;
                    awready_d  = 1'b0;
                    wready_d   = 1'b1;
                    wr_state_d = StWrData;
                end
            end
            StWrData: begin
                if (w_hs) begin
                    wr_addr_d = wr_next;
                    if (s_axi_wlast) begin
                        wready_d   = 1'b0;
                        bvalid_d   = 1'b1;
                        wr_state_d = StWrResp;
                    end
                end
            end
            StWrResp: begin
                if (s_axi_bready) begin
                    bvalid_d   = 1'b0;
                    awready_d  = 1'b1;
                    wr_state_d = StWrIdle;
                end
            end
            default: begin
                wready_d   = 1'b0;
                bvalid_d   = 1'b0;
                wr_state_d = StWrIdle;
            end
        endcase
    end

    always_ff @(posedge s_aclk or posedge s_areset) begin
        if (s_areset) begin
            rd_state_q <= StRdIdle;
            rd_addr_q  <= '0;
            rd_len_q   <= '0;
            rd_cnt_q   <= '0;
            rd_size_q  <= '0;
            rd_burst_q <= '0;
            rid_q      <= '0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
            rlast_q    <= 1'b0;
            arready_q  <= 1'b0;
            wr_state_q <= StWrIdle;
            wr_addr_q  <= '0;
            wr_size_q  <= '0;
            wr_burst_q <= '0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
        end else begin
            rd_state_q <= rd_state_d;
            rd_addr_q  <= rd_addr_d;
            rd_len_q   <= rd_len_d;
            rd_cnt_q   <= rd_cnt_d;
            rd_size_q  <= rd_size_d;
            rd_burst_q <= rd_burst_d;
            rid_q      <= rid_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
            rlast_q    <= rlast_d;
            arready_q  <= arready_d;
            wr_state_q <= wr_state_d;
            wr_addr_q  <= wr_addr_d;
            wr_size_q  <= wr_size_d;
            wr_burst_q <= wr_burst_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
        end
    end

    // Contents survive reset; the read path samples before this update (read-first).
    always_ff @(posedge s_aclk) begin
        if (w_hs) begin
            for (int b = 0; b < StrbW; b++) begin
                if (s_axi_wstrb[b]) begin
                    mem_q[wr_addr_q[BYTE_OFS +: IdxW]][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
                end
            end
        end
    end

    assign s_axi_arready = arready_q;
    assign s_axi_rid     = rid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = RESP_OKAY;
    assign s_axi_rlast   = rlast_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bresp   = RESP_OKAY;
    assign s_axi_bvalid  = bvalid_q;

endmodule

// File: tb/tb_sim_axi_blk_ram.sv
// Randomised bench for sim_axi_blk_ram against a word-array memory model.
module tb_sim_axi_blk_ram;

    localparam int unsigned Depth = 4096;
    localparam int          Tmo   = 2000;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   s_axi_arid = '0;
    logic [47:0]  s_axi_araddr = '0;
    logic [1:0]   s_axi_arburst = '0;
    logic [7:0]   s_axi_arlen = '0;
    logic [2:0]   s_axi_arsize = '0;
    logic         s_axi_arvalid = 1'b0;
    logic         s_axi_arready;
    logic [3:0]   s_axi_rid;
    logic [255:0] s_axi_rdata;
    logic [1:0]   s_axi_rresp;
    logic         s_axi_rlast;
    logic         s_axi_rvalid;
    logic         s_axi_rready = 1'b0;
    logic [47:0]  s_axi_awaddr = '0;
    logic [1:0]   s_axi_awburst = '0;
    logic [7:0]   s_axi_awlen = '0;
    logic [2:0]   s_axi_awsize = '0;
    logic         s_axi_awvalid = 1'b0;
    logic         s_axi_awready;
    logic [255:0] s_axi_wdata = '0;
    logic [31:0]  s_axi_wstrb = '0;
    logic         s_axi_wlast = 1'b0;
    logic         s_axi_wvalid = 1'b0;
    logic         s_axi_wready;
    logic [1:0]   s_axi_bresp;
    logic         s_axi_bvalid;
    logic         s_axi_bready = 1'b0;

    always #5 clk = ~clk;

    sim_axi_blk_ram #(
        .ADDR_WIDTH (48),
        .DATA_WIDTH (256),
        .ID_WIDTH   (4),
        .MEM_DEPTH  (Depth)
    ) dut (
        .s_aclk        (clk),
        .s_areset      (rst),
        .s_axi_arid    (s_axi_arid),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arburst (s_axi_arburst),
        .s_axi_arlen   (s_axi_arlen),
        .s_axi_arsize  (s_axi_arsize),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rid     (s_axi_rid),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rlast   (s_axi_rlast),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awburst (s_axi_awburst),
        .s_axi_awlen   (s_axi_awlen),
        .s_axi_awsize  (s_axi_awsize),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wlast   (s_axi_wlast),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready)
    );

    logic [255:0] ref_mem [Depth];
    logic [255:0] wb_data [256];
    logic [31:0]  wb_strb [256];
    logic [1:0]   b_resp_seen;
    int           n_total = 0;
    int           n_bad = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int unsigned word_of(input logic [47:0] a);
        return 32'((a / 48'd32) % 48'(Depth));
    endfunction

    function automatic logic [47:0] step(input logic [47:0] a, input logic [1:0] burst,
                                         input logic [2:0] size);
        if (burst == 2'd0) return a;
        return a + (48'd1 << size);
    endfunction

    task automatic model_write(input logic [47:0] a, input logic [255:0] d, input logic [31:0] s);
        int unsigned w = word_of(a);
        for (int b = 0; b < 32; b++) begin
            if (s[b]) ref_mem[w][b*8 +: 8] = d[b*8 +: 8];
        end
    endtask

    // Called just after a rising edge; returns just after the edge that completed the handshake.
    task automatic wait_hs(input int ch, input string tag, output bit ok);
        bit r;
        int n = 0;
        do begin
            @(negedge clk);
            case (ch)
                0:       r = s_axi_arready;
                1:       r = s_axi_awready;
                2:       r = s_axi_wready;
                default: begin r = s_axi_bvalid; b_resp_seen = s_axi_bresp; end
            endcase
            @(posedge clk);
            #1;
            n++;
        end while (!r && n < Tmo);
        ok = r;
        if (!r) check({tag, "_timeout"}, 256'd0, 256'd1);
    endtask

    task automatic axi_write(input logic [47:0] addr, input logic [1:0] burst, input int len,
                             input logic [2:0] size);
        bit ok;
        logic [47:0] a;
        s_axi_awaddr  = addr;
        s_axi_awburst = burst;
        s_axi_awlen   = 8'(len);
        s_axi_awsize  = size;
        s_axi_awvalid = 1'b1;
        wait_hs(1, "aw", ok);
        s_axi_awvalid = 1'b0;
        if (!ok) return;
        a = addr;
        for (int k = 0; k <= len; k++) begin
            s_axi_wdata  = wb_data[k];
            s_axi_wstrb  = wb_strb[k];
            s_axi_wlast  = (k == len);
            s_axi_wvalid = 1'b1;
            wait_hs(2, "w", ok);
            if (!ok) break;
            model_write(a, wb_data[k], wb_strb[k]);
            a = step(a, burst, size);
        end
        s_axi_wvalid = 1'b0;
        s_axi_wlast  = 1'b0;
        if (!ok) return;
        s_axi_bready = 1'b1;
        wait_hs(3, "b", ok);
        s_axi_bready = 1'b0;
        if (ok) check("bresp", 256'(b_resp_seen), 256'd0);
    endtask

    // mode 0: always ready (also checks no bubbles), 1: toggling, 2: random.
    task automatic axi_read(input logic [47:0] addr, input logic [1:0] burst, input int len,
                            input logic [2:0] size, input int mode);
        bit ok;
        logic [47:0] a;
        logic [3:0] id;
        int k = 0;
        int n = 0;
        id = 4'($urandom);
        s_axi_arid    = id;
        s_axi_araddr  = addr;
        s_axi_arburst = burst;
        s_axi_arlen   = 8'(len);
        s_axi_arsize  = size;
        s_axi_arvalid = 1'b1;
        s_axi_rready  = 1'b0;
        wait_hs(0, "ar", ok);
        s_axi_arvalid = 1'b0;
        if (!ok) return;
        a = addr;
        while (k <= len && n < Tmo) begin
            case (mode)
                0:       s_axi_rready = 1'b1;
                1:       s_axi_rready = (n % 2 == 0);
                default: s_axi_rready = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            if (mode == 0) check("r_gap", 256'(s_axi_rvalid), 256'd1);
            if (s_axi_rvalid) begin
                check("rdata", s_axi_rdata, ref_mem[word_of(a)]);
                check("rlast", 256'(s_axi_rlast), 256'(k == len));
                check("rid", 256'(s_axi_rid), 256'(id));
                check("rresp", 256'(s_axi_rresp), 256'd0);
                if (s_axi_rready) begin
                    k++;
                    a = step(a, burst, size);
                end
            end
            @(posedge clk);
            #1;
            n++;
        end
        s_axi_rready = 1'b0;
        if (k <= len) check("r_timeout", 256'd0, 256'd1);
        @(negedge clk);
        check("r_after_last", 256'(s_axi_rvalid), 256'd0);
        check("arready_again", 256'(s_axi_arready), 256'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit ok;
        logic [255:0] old_val;
        logic [47:0]  addr;
        for (int i = 0; i < Depth; i++) ref_mem[i] = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_arready", 256'(s_axi_arready), 256'd0);
        check("rst_awready", 256'(s_axi_awready), 256'd0);
        check("rst_wready", 256'(s_axi_wready), 256'd0);
        check("rst_rvalid", 256'(s_axi_rvalid), 256'd0);
        check("rst_rlast", 256'(s_axi_rlast), 256'd0);
        check("rst_bvalid", 256'(s_axi_bvalid), 256'd0);
        check("rst_rdata", s_axi_rdata, 256'd0);
        check("rst_rid", 256'(s_axi_rid), 256'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_arready", 256'(s_axi_arready), 256'd1);
        check("post_rst_awready", 256'(s_axi_awready), 256'd1);

        // Zero words 0..511 so every later read has a defined expectation.
        for (int k = 0; k < 256; k++) begin
            wb_data[k] = '0;
            wb_strb[k] = '1;
        end
        axi_write(48'h0, 2'd1, 255, 3'd5);
        axi_write(48'h2000, 2'd1, 255, 3'd5);

        wb_data[0] = {32{8'hA5}};
        axi_write(48'h40, 2'd1, 0, 3'd5);
        axi_read(48'h40, 2'd1, 0, 3'd5, 0);

        for (int k = 0; k < 4; k++) wb_data[k] = 256'(k + 1);
        axi_write(48'h0, 2'd1, 3, 3'd5);
        axi_read(48'h0, 2'd1, 3, 3'd5, 0);

        wb_data[0] = '0;
        axi_write(48'h80, 2'd1, 0, 3'd5);
        wb_data[0] = '1;
        wb_strb[0] = 32'h0000_000F;
        axi_write(48'h80, 2'd1, 0, 3'd5);
        axi_read(48'h80, 2'd1, 0, 3'd5, 0);

        for (int k = 0; k < 8; k++) begin
            wb_data[k] = {8{$urandom}};
            wb_strb[k] = '1;
        end
        axi_write(48'h400, 2'd1, 7, 3'd5);
        axi_read(48'h400, 2'd1, 7, 3'd5, 1);

        // Same-edge write and read of word 0x100: read must see the old contents.
        wb_data[0] = {8{$urandom}};
        axi_write(48'h2000, 2'd1, 0, 3'd5);
        old_val = ref_mem[256];
        s_axi_awaddr  = 48'h2000;
        s_axi_awburst = 2'd1;
        s_axi_awlen   = 8'd0;
        s_axi_awsize  = 3'd5;
        s_axi_awvalid = 1'b1;
        wait_hs(1, "aw_sim", ok);
        s_axi_awvalid = 1'b0;
        s_axi_wdata   = {8{$urandom}};
        s_axi_wstrb   = '1;
        s_axi_wlast   = 1'b1;
        s_axi_wvalid  = 1'b1;
        s_axi_arid    = 4'd9;
        s_axi_araddr  = 48'h2000;
        s_axi_arburst = 2'd1;
        s_axi_arlen   = 8'd0;
        s_axi_arsize  = 3'd5;
        s_axi_arvalid = 1'b1;
        @(negedge clk);
        check("sim_wready", 256'(s_axi_wready), 256'd1);
        check("sim_arready", 256'(s_axi_arready), 256'd1);
        @(posedge clk);
        #1;
        s_axi_wvalid  = 1'b0;
        s_axi_wlast   = 1'b0;
        s_axi_arvalid = 1'b0;
        model_write(48'h2000, s_axi_wdata, s_axi_wstrb);
        @(negedge clk);
        check("sim_rvalid", 256'(s_axi_rvalid), 256'd1);
        check("sim_rdata_old", s_axi_rdata, old_val);
        check("sim_bvalid", 256'(s_axi_bvalid), 256'd1);
        @(posedge clk);
        #1;
        s_axi_rready = 1'b1;
        s_axi_bready = 1'b1;
        @(posedge clk);
        #1;
        s_axi_rready = 1'b0;
        s_axi_bready = 1'b0;
        @(negedge clk);
        check("sim_b_done", 256'(s_axi_bvalid), 256'd0);
        @(posedge clk);
        #1;
        axi_read(48'h2000, 2'd1, 0, 3'd5, 0);

        for (int it = 0; it < 40; it++) begin
            int len;
            len = int'($urandom_range(0, 15));
            for (int k = 0; k <= len; k++) begin
                wb_data[k] = {8{$urandom}};
                wb_strb[k] = ($urandom_range(0, 3) == 0) ? '1 : $urandom;
            end
            addr = (48'($urandom) << 17) | (48'($urandom_range(0, 495)) << 5)
                 | 48'($urandom_range(0, 31));
            axi_write(addr, 2'($urandom_range(0, 2)), len, 3'($urandom_range(0, 5)));
            len  = int'($urandom_range(0, 15));
            addr = (48'($urandom) << 17) | (48'($urandom_range(0, 495)) << 5)
                 | 48'($urandom_range(0, 31));
            axi_read(addr, 2'($urandom_range(0, 2)), len, 3'($urandom_range(0, 5)),
                     int'($urandom_range(0, 2)));
        end

        // Reset in the middle of an 8-beat read.
        s_axi_arid    = 4'd3;
        s_axi_araddr  = 48'h400;
        s_axi_arburst = 2'd1;
        s_axi_arlen   = 8'd7;
        s_axi_arsize  = 3'd5;
        s_axi_arvalid = 1'b1;
        wait_hs(0, "ar_rst", ok);
        s_axi_arvalid = 1'b0;
        s_axi_rready  = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        s_axi_rready = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("mid_rst_rvalid", 256'(s_axi_rvalid), 256'd0);
        check("mid_rst_rlast", 256'(s_axi_rlast), 256'd0);
        check("mid_rst_arready", 256'(s_axi_arready), 256'd0);
        check("mid_rst_rdata", s_axi_rdata, 256'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rel_arready", 256'(s_axi_arready), 256'd1);
        check("rel_rvalid", 256'(s_axi_rvalid), 256'd0);
        axi_read(48'h400, 2'd1, 7, 3'd5, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
